// File: rtl/seq_shift_unit.sv
// Iterative shifter (SLL/SRL/SRA) with valid/ready on both sides.
// Define SEQ_SHIFT_RADIX4_EN to shift up to four bits per cycle.
package rv32i_pkg;
    localparam int DPW = 32;
endpackage

module seq_shift_unit
    import rv32i_pkg::*;
#(
    parameter  int DPW_P = rv32i_pkg::DPW,
    localparam int SAW   = $clog2(DPW_P)
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DPW_P-1:0] shift_number,
    input  logic [SAW-1:0]   shift_amount,
    input  logic             is_left,
    input  logic             MSB_ext,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DPW_P-1:0] res,
    output logic             busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [DPW_P-1:0] work_q, work_d;
    logic [SAW-1:0]   cnt_q, cnt_d;
    logic             fill_q, fill_d;
    logic             left_q, left_d;

    logic             accept;
    logic             last_step;
    logic [SAW-1:0]   step;
    logic [DPW_P-1:0] shl, shr;

    // Handshake outputs decode from state only, never from the peer's strobe.
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign res       = work_q;
    assign accept    = in_valid & in_ready;

`ifdef SEQ_SHIFT_RADIX4_EN
    localparam logic [SAW-1:0] STEP_MAX = SAW'(4);

    assign step      = (cnt_q > STEP_MAX) ? STEP_MAX : cnt_q;
    assign last_step = (cnt_q <= STEP_MAX);
    assign shl       = work_q << step;
    // Complement trick gives a ones-fill right shift.
    assign shr       = fill_q ? ~((~work_q) >> step)
                              : (work_q >> step);
`else
    assign step      = SAW'(1);
    assign last_step = (cnt_q == SAW'(1));
    assign shl       = {work_q[DPW_P-2:0], 1'b0};
    assign shr       = {fill_q, work_q[DPW_P-1:1]};
`endif

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        left_d  = left_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    work_d  = shift_number;
                    cnt_d   = shift_amount;
                    left_d  = is_left;
                    fill_d  = ~is_left & MSB_ext
                            & shift_number[DPW_P-1];
                    state_d = (shift_amount != '0) ? S_SHIFT
                                                   : S_DONE;
                end
            end
            S_SHIFT: begin
                work_d = left_q ? shl : shr;
                cnt_d  = cnt_q - step;
                if (last_step) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            fill_q  <= 1'b0;
            left_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            left_q  <= left_d;
        end
    end

`ifndef SYNTHESIS
    a_no_overlap: assert property (
        @(posedge clk) disable iff (!arst_n)
        !(in_ready && out_valid));

    a_res_hold: assert property (
        @(posedge clk) disable iff (!arst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(res)));
`endif

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed and random checks for seq_shift_unit.
// Expected results come from hand tables and a <<, >>, >>> model.
module tb_seq_shift_unit;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] shift_number;
    logic [4:0]  shift_amount;
    logic        is_left;
    logic        MSB_ext;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_shift_unit dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .shift_number (shift_number),
        .shift_amount (shift_amount),
        .is_left      (is_left),
        .MSB_ext      (MSB_ext),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .res          (res),
        .busy         (busy)
    );

    typedef struct {
        logic [31:0] num;
        logic [4:0]  amt;
        logic        left;
        logic        ext;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic int lat_of(input int n);
`ifdef SEQ_SHIFT_RADIX4_EN
        return (n == 0) ? 1 : (n + 3) / 4 + 1;
`else
        return n + 1;
`endif
    endfunction

    function automatic logic [31:0] model(input logic [31:0] n,
                                          input logic [4:0]  a,
                                          input logic        l,
                                          input logic        e);
        logic signed [31:0] s;
        s = n;
        if (l) return n << a;
        if (e) return 32'(s >>> a);
        return n >> a;
    endfunction

    // One request with out_ready high; checks latency, result, handshake.
    task automatic run_vec(input vec_t v, input int idx);
        int  cyc;
        bit  found;
        @(negedge clk);
        in_valid     = 1'b1;
        shift_number = v.num;
        shift_amount = v.amt;
        is_left      = v.left;
        MSB_ext      = v.ext;
        out_ready    = 1'b1;
        chk($sformatf("v%0d_in_ready", idx), 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        cyc   = 0;
        found = 1'b0;
        while (!found && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (out_valid) found = 1'b1;
        end
        chk($sformatf("v%0d_latency", idx), 32'(cyc),
            32'(lat_of(int'(v.amt))));
        chk($sformatf("v%0d_res", idx), res, v.exp);
        chk($sformatf("v%0d_rdy_low", idx), 32'(in_ready), 32'd0);
        @(negedge clk);
        chk($sformatf("v%0d_idle", idx),
            {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        int          sent, got, cyc, k, pulse_cyc;
        bit          need_new;
        logic [31:0] expq[$];
        logic [31:0] nexp;

        vecs[0]  = '{32'h0000_0001, 5'd31, 1'b1, 1'b0, 32'h8000_0000};
        vecs[1]  = '{32'h8000_00F0, 5'd4,  1'b0, 1'b1, 32'hF800_000F};
        vecs[2]  = '{32'h8000_00F0, 5'd4,  1'b0, 1'b0, 32'h0800_000F};
        vecs[3]  = '{32'hDEAD_BEEF, 5'd0,  1'b1, 1'b0, 32'hDEAD_BEEF};
        vecs[4]  = '{32'h8000_0000, 5'd31, 1'b0, 1'b1, 32'hFFFF_FFFF};
        vecs[5]  = '{32'h8000_0000, 5'd31, 1'b0, 1'b0, 32'h0000_0001};
        vecs[6]  = '{32'h1234_5678, 5'd4,  1'b1, 1'b1, 32'h2345_6780};
        vecs[7]  = '{32'hF000_0000, 5'd8,  1'b0, 1'b0, 32'h00F0_0000};
        vecs[8]  = '{32'hFFFF_FFFF, 5'd1,  1'b1, 1'b0, 32'hFFFF_FFFE};
        vecs[9]  = '{32'h7FFF_FFFF, 5'd3,  1'b0, 1'b1, 32'h0FFF_FFFF};
        vecs[10] = '{32'hDEAD_BEEF, 5'd0,  1'b0, 1'b1, 32'hDEAD_BEEF};

        arst_n       = 1'b0;
        in_valid     = 1'b0;
        shift_number = '0;
        shift_amount = '0;
        is_left      = 1'b0;
        MSB_ext      = 1'b0;
        out_ready    = 1'b0;
        #12;
        chk("rst_state", {28'd0, in_ready, out_valid, busy, 1'b0},
            32'b1000);
        chk("rst_res", res, 32'd0);
        @(negedge clk);
        arst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Backpressure: result held, new request not taken until handshake.
        @(negedge clk);
        in_valid     = 1'b1;
        shift_number = 32'h0000_00FF;
        shift_amount = 5'd8;
        is_left      = 1'b1;
        out_ready    = 1'b0;
        @(posedge clk);
        #1 shift_number = 32'h0000_0003;
        shift_amount = 5'd2;
        cyc = 0;
        while (!out_valid && cyc < 80) begin
            @(negedge clk);
            cyc++;
        end
        chk("bp_latency", 32'(cyc), 32'(lat_of(8)));
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_hold", {29'd0, out_valid, in_ready, busy},
                32'b101);
            chk("bp_res", res, 32'h0000_FF00);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", {30'd0, out_valid, in_ready}, 32'b01);
        @(posedge clk);
        #1 in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 80) begin
            @(negedge clk);
            cyc++;
        end
        chk("bp_next_lat", 32'(cyc), 32'(lat_of(2)));
        chk("bp_next_res", res, 32'h0000_000C);
        @(negedge clk);

        // Reset while shifting drops the operation.
`ifdef SEQ_SHIFT_RADIX4_EN
        pulse_cyc = 3;
`else
        pulse_cyc = 6;
`endif
        @(negedge clk);
        in_valid     = 1'b1;
        shift_number = 32'h1234_5678;
        shift_amount = 5'd20;
        is_left      = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int c = 1; c < pulse_cyc; c++) begin
            @(negedge clk);
            chk("rm_pre_valid", 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        arst_n = 1'b0;
        #1;
        chk("rm_rst_out", {29'd0, in_ready, out_valid, busy},
            32'b100);
        chk("rm_rst_res", res, 32'd0);
        @(negedge clk);
        arst_n = 1'b1;
        k = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (out_valid) k++;
        end
        chk("rm_no_valid", 32'(k), 32'd0);
        chk("rm_after", {29'd0, in_ready, busy, out_valid}, 32'b100);
        run_vec('{32'h1, 5'd1, 1'b1, 1'b0, 32'h2}, 99);

        // Random traffic with a scoreboard queue.
        sent     = 0;
        got      = 0;
        cyc      = 0;
        need_new = 1'b1;
        nexp     = '0;
        while ((sent < 1000 || expq.size() != 0) && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (need_new) begin
                if (sent < 1000) begin
                    in_valid     = 1'b1;
                    shift_number = $urandom;
                    shift_amount = 5'($urandom_range(0, 31));
                    is_left      = 1'($urandom);
                    MSB_ext      = 1'($urandom);
                    nexp = model(shift_number, shift_amount,
                                 is_left, MSB_ext);
                end else begin
                    in_valid = 1'b0;
                end
                need_new = 1'b0;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            if (in_valid && in_ready) begin
                expq.push_back(nexp);
                sent++;
                need_new = 1'b1;
            end
            if (out_valid && out_ready) begin
                got++;
                if (expq.size() == 0) begin
                    chk("rnd_extra", 32'd1, 32'd0);
                end else begin
                    chk($sformatf("rnd_res%0d", got), res,
                        expq.pop_front());
                end
            end
        end
        in_valid = 1'b0;
        chk("rnd_timeout", 32'(cyc < 60000), 32'd1);
        chk("rnd_count", 32'(got), 32'(sent));
        chk("rnd_sent", 32'(sent), 32'd1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_shift_unit.md
Name: seq_shift_unit

Overview:
- Multi-cycle iterative shift unit for the rv32i datapath.
- Performs logical left, logical right and arithmetic right shifts on a DPW-bit operand, one bit position per cycle.
- Natively shifts in either direction, with no bit-reversal of the operand.
- Sits beside the ALU as the low-area shift path. Uses a valid/ready handshake on both input and output so the issue stage can stall on it.

Parameters:
- DPW, rv32i_pkg::DPW (32), datapath width in bits.
- SAW, $clog2(DPW) (5), shift amount width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- arst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- shift_number  in  DPW  operand.
- shift_amount  in  SAW  shift distance, 0..DPW-1.
- is_left  in  1  1 = left shift, 0 = right shift.
- MSB_ext  in  1  right shift only: 1 = arithmetic (fill with operand MSB), 0 = logical (fill 0). Ignored for left shifts.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- res  out  DPW  shift result.
- busy  out  1  high in SHIFT or DONE.

Behaviour:
- Reset (arst_n low, asynchronous, any state):
  - state = IDLE; in_ready = 1; out_valid = 0; busy = 0; res = 0; internal counter = 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On an accept edge (in_valid & in_ready), capture shift_number into the working register and shift_amount into cnt.
  - Capture the fill bit: left shift -> 0; right shift -> MSB_ext & shift_number[DPW-1].
  - Capture the direction.
  - Next state: SHIFT if shift_amount != 0, else DONE.
- SHIFT:
  - Each edge shifts the working register by one position. Left inserts 0 at bit 0; right inserts the fill bit at bit DPW-1.
  - Each edge decrements cnt.
  - When cnt == 1 at the edge, transition to DONE.
  - in_ready = 0; inputs are ignored.
- DONE:
  - out_valid = 1; res = working register.
  - res is stable while out_valid & !out_ready.
  - On an edge with out_ready = 1, transition to IDLE.
- Latency, with the accept edge ending cycle 0: out_valid is first high in cycle N+1, N = shift_amount.
  - N = 0 -> cycle 1.
  - N = 31 -> cycle 32.
- No overlap: the next request is accepted only in IDLE.
  - in_ready is never high in the same cycle as out_valid.
  - After a handshake in DONE, in_ready is high in the following cycle.
- res is updated only in SHIFT and at the accept edge; it is not cleared on return to IDLE.
- out_valid must not depend combinationally on out_ready, and in_ready must not depend combinationally on in_valid.
- Reset asserted mid-SHIFT or in DONE:
  - The operation is dropped and no out_valid is issued.
  - After arst_n deasserts, the unit is in IDLE with in_ready = 1.
- Arithmetic right shift of a negative operand with N = DPW-1 yields all ones. Logical shift with N = DPW-1 leaves a single bit.

Optional Feature:
- Macro: SEQ_SHIFT_RADIX4_EN.
- Defined: each SHIFT edge shifts by min(cnt, 4) positions and decrements cnt by the same amount. SHIFT exits when cnt <= 4 at the edge.
  - Latency: cycle 1 for N = 0, else cycle ceil(N/4)+1.
  - Example: N = 31 -> cycle 9; N = 4 -> cycle 2.
- Undefined: one bit per edge, latency N+1 as above.
- Results are bit-identical in both builds.

Test Plan:
- Logical left: shift_number = 0x0000_0001, shift_amount = 31, is_left = 1, out_ready = 1.
  -> res = 0x8000_0000; out_valid first high in cycle 32 (cycle 9 with SEQ_SHIFT_RADIX4_EN).
- Arithmetic right: 0x8000_00F0, amount 4, is_left = 0, MSB_ext = 1.
  -> res = 0xF800_000F. Same stimulus with MSB_ext = 0 -> 0x0800_000F.
- Zero shift: 0xDEAD_BEEF, amount 0.
  -> res = 0xDEAD_BEEF with out_valid in cycle 1; in_ready low during cycle 1.
- Backpressure: 0x0000_00FF, amount 8, left, out_ready held 0 for 5 cycles after out_valid.
  -> res = 0x0000_FF00 stable and out_valid high throughout; in_valid held high during that time is not accepted.
  -> Handshake completes on the first edge with out_ready = 1; the next request is accepted one cycle later.
- Reset mid-operation: start 0x1234_5678, amount 20; pulse arst_n low in cycle 6.
  -> out_valid never rises for that request.
  -> After arst_n returns high: in_ready = 1, busy = 0, res = 0.
  -> A new request 0x1, amount 1, left -> res = 0x2 in cycle 2.
- Back-to-back random: 1000 requests with random operand, amount, direction and MSB_ext, and random out_ready stalls.
  -> Every res matches the reference model (<<, >>, >>>).
  -> The number of results equals the number of accepted requests, with no duplicates.
